// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the LC-3 memory access controller.
package lc3_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_ACCESS  = 3'd2,
        ST_DONE    = 3'd3,
        ST_IO_DONE = 3'd4
    } mem_state_t;

    localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Control-unit request/response, SRAM pins and board I/O of the memory stage.
interface mem_access_ctrl_if #(
    parameter int SRAM_AW = 20
);
    // Req is a level; a new access begins only on its rising edge while idle,
    // and R answers each accepted access with exactly one one-cycle pulse.
    logic               Req;
    logic               WE;
    logic [15:0]        MAR;
    logic [15:0]        MDR;
    logic [15:0]        MDR_In;
    logic               R;
    logic [SRAM_AW-1:0] SRAM_ADDR;
    logic [15:0]        Data_to_SRAM;
    logic [15:0]        Data_from_SRAM;
    logic               CE_N;
    logic               OE_N;
    logic               WE_N;
    logic               UB_N;
    logic               LB_N;
    logic [15:0]        Switches;
    logic [15:0]        HEX_Data;

    modport master (
        output Req, WE, MAR, MDR, Data_from_SRAM, Switches,
        input  MDR_In, R, SRAM_ADDR, Data_to_SRAM, CE_N, OE_N, WE_N, UB_N, LB_N, HEX_Data
    );

    modport slave (
        input  Req, WE, MAR, MDR, Data_from_SRAM, Switches,
        output MDR_In, R, SRAM_ADDR, Data_to_SRAM, CE_N, OE_N, WE_N, UB_N, LB_N, HEX_Data
    );

endinterface

// File: rtl/mem_access_ctrl_wait_counter.sv
// Strobe-width counter: counts up while enabled, terminal count at WAIT_CYCLES-1.
module mem_wait_counter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic Clk,
    input  logic Reset,
    input  logic clear,
    input  logic en,
    output logic tc
);
    localparam logic [3:0] TC_VAL = 4'(WAIT_CYCLES - 1);

    logic [3:0] count;

    always_ff @(posedge Clk) begin
        if (Reset || clear) begin
            count <= 4'd0;
        end else if (en) begin
            count <= count + 4'd1;
        end
    end

    assign tc = (count == TC_VAL);

endmodule

// File: rtl/mem_access_ctrl.sv
// LC-3 memory stage: timed asynchronous SRAM cycle plus switch/hex I/O at IO_ADDR.
module mem_access_ctrl
    import lc3_mem_pkg::*;
#(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [15:0] IO_ADDR     = IO_ADDR_DEFAULT,
    parameter int          SRAM_AW     = 20
) (
    input  logic                   Clk,
    input  logic                   Reset,
    mem_access_ctrl_if.slave       bus,
    output mem_state_t             state_dbg
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP   = 3'd1;
    localparam logic [2:0] S_ACCESS  = 3'd2;
    localparam logic [2:0] S_DONE    = 3'd3;
    localparam logic [2:0] S_IO_DONE = 3'd4;

    generate
        if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
            $fatal(1, "mem_access_ctrl: WAIT_CYCLES must be in 1..15");
        end
    endgenerate

    logic [2:0]  state;
    logic [2:0]  state_next;
    logic        req_d;
    logic [15:0] addr_q;
    logic [15:0] data_q;
    logic        we_q;
    logic [15:0] mdr_in_q;
    logic [15:0] hex_q;
    logic        start;
    logic        io_hit;
    logic        hex_load;
    logic        wait_tc;

    assign start    = (state == S_IDLE) && bus.Req && !req_d;
    // Decode from the live MAR so I/O completes on the start edge itself.
    assign io_hit   = (bus.MAR == IO_ADDR);
    assign hex_load = start && io_hit && bus.WE;

    mem_wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait (
        .Clk   (Clk),
        .Reset (Reset),
        .clear (state == S_SETUP),
        .en    (state == S_ACCESS),
        .tc    (wait_tc)
    );

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (start) state_next = io_hit ? S_IO_DONE : S_SETUP;
            S_SETUP:   state_next = S_ACCESS;
            S_ACCESS:  if (wait_tc) state_next = S_DONE;
            S_DONE:    state_next = S_IDLE;
            S_IO_DONE: state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= S_IDLE;
            req_d    <= 1'b0;
            addr_q   <= 16'd0;
            data_q   <= 16'd0;
            we_q     <= 1'b0;
            mdr_in_q <= 16'd0;
        end else begin
            state <= state_next;
            req_d <= bus.Req;
            if (start) begin
                addr_q <= bus.MAR;
                data_q <= bus.MDR;
                we_q   <= bus.WE;
                if (io_hit && !bus.WE) begin
                    mdr_in_q <= bus.Switches;
                end
            end
            // SRAM data is sampled as the last strobe cycle closes.
            if (state == S_ACCESS && wait_tc && !we_q) begin
                mdr_in_q <= bus.Data_from_SRAM;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            hex_q <= 16'd0;
        end else if (hex_load) begin
            hex_q <= bus.MDR;
        end
    end

    logic sram_active;
    logic data_drive;

    assign sram_active = (state == S_SETUP) || (state == S_ACCESS);
    assign data_drive  = sram_active || (state == S_DONE);

    assign bus.CE_N         = !sram_active;
    assign bus.UB_N         = !sram_active;
    assign bus.LB_N         = !sram_active;
    assign bus.OE_N         = !((state == S_ACCESS) && !we_q);
    assign bus.WE_N         = !((state == S_ACCESS) && we_q);
    assign bus.SRAM_ADDR    = {{(SRAM_AW-16){1'b0}}, addr_q};
    assign bus.Data_to_SRAM = data_drive ? data_q : 16'd0;
    assign bus.R            = (state == S_DONE) || (state == S_IO_DONE);
    assign bus.MDR_In       = mdr_in_q;
    assign bus.HEX_Data     = hex_q;
    assign state_dbg        = mem_state_t'(state);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: SRAM read/write, I/O, reset abort, Req edge handling.
module tb_mem_access_ctrl;
    import lc3_mem_pkg::*;

    logic       Clk;
    logic       Reset;
    mem_state_t state_dbg;

    int compared;
    int mismatched;
    int oe_lo;
    int we_lo;
    int ce_lo;
    int r_cnt;
    int bad_data;

    mem_access_ctrl_if #(.SRAM_AW(20)) bus ();

    mem_access_ctrl #(
        .WAIT_CYCLES (2),
        .IO_ADDR     (16'hFFFF),
        .SRAM_AW     (20)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // One clock: inputs already set before the posedge, outputs sampled at negedge.
    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
        if (!bus.OE_N) oe_lo++;
        if (!bus.WE_N) we_lo++;
        if (!bus.CE_N) begin
            ce_lo++;
            if (bus.Data_to_SRAM !== 16'h1234) bad_data++;
        end
        if (bus.R) r_cnt++;
    endtask

    task automatic clear_counts();
        oe_lo = 0; we_lo = 0; ce_lo = 0; r_cnt = 0; bad_data = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        clear_counts();
        Reset = 1'b1;
        bus.Req = 1'b0;
        bus.WE = 1'b0;
        bus.MAR = 16'h0000;
        bus.MDR = 16'h0000;
        bus.Data_from_SRAM = 16'h0000;
        bus.Switches = 16'h0000;

        // Reset held three cycles
        repeat (3) tick();
        Reset = 1'b0;
        check("rst_strobes", 32'({bus.CE_N, bus.OE_N, bus.WE_N, bus.UB_N, bus.LB_N}), 32'h1F);
        check("rst_r", 32'(bus.R), 32'h0);
        check("rst_mdr_in", 32'(bus.MDR_In), 32'h0);
        check("rst_hex", 32'(bus.HEX_Data), 32'h0);
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        check("rst_addr", 32'(bus.SRAM_ADDR), 32'h0);
        check("rst_dout", 32'(bus.Data_to_SRAM), 32'h0);
        tick();

        // SRAM read, single-cycle Req pulse
        clear_counts();
        bus.MAR = 16'h3000; bus.WE = 1'b0; bus.Data_from_SRAM = 16'hBEEF; bus.Req = 1'b1;
        tick();
        check("rd_setup_state", 32'(state_dbg), 32'(ST_SETUP));
        check("rd_setup_ce", 32'({bus.CE_N, bus.UB_N, bus.LB_N, bus.OE_N}), 32'h1);
        check("rd_addr", 32'(bus.SRAM_ADDR), 32'h03000);
        bus.Req = 1'b0;
        tick();
        check("rd_acc_oe", 32'(bus.OE_N), 32'h0);
        tick();
        check("rd_r_early", 32'(bus.R), 32'h0);
        tick();
        check("rd_r", 32'(bus.R), 32'h1);
        check("rd_mdr_in", 32'(bus.MDR_In), 32'hBEEF);
        check("rd_done_strobes", 32'({bus.CE_N, bus.OE_N, bus.WE_N, bus.UB_N, bus.LB_N}), 32'h1F);
        tick();
        check("rd_idle_r", 32'(bus.R), 32'h0);
        check("rd_oe_cycles", 32'(oe_lo), 32'd2);
        check("rd_r_count", 32'(r_cnt), 32'd1);

        // SRAM write with Req held high for ten cycles
        clear_counts();
        bus.MAR = 16'h0042; bus.MDR = 16'h1234; bus.WE = 1'b1; bus.Req = 1'b1;
        repeat (10) tick();
        bus.Req = 1'b0;
        repeat (2) tick();
        check("wr_we_cycles", 32'(we_lo), 32'd2);
        check("wr_oe_cycles", 32'(oe_lo), 32'd0);
        check("wr_ce_cycles", 32'(ce_lo), 32'd3);
        check("wr_data_bad", 32'(bad_data), 32'd0);
        check("wr_r_count", 32'(r_cnt), 32'd1);
        check("wr_mdr_in_kept", 32'(bus.MDR_In), 32'hBEEF);
        check("wr_idle_dout", 32'(bus.Data_to_SRAM), 32'h0);

        // I/O read of switches
        clear_counts();
        bus.Switches = 16'h00A5; bus.MAR = 16'hFFFF; bus.WE = 1'b0; bus.Req = 1'b1;
        tick();
        check("io_rd_r", 32'(bus.R), 32'h1);
        check("io_rd_state", 32'(state_dbg), 32'(ST_IO_DONE));
        check("io_rd_mdr_in", 32'(bus.MDR_In), 32'h00A5);
        bus.Req = 1'b0;
        tick();
        check("io_rd_r_low", 32'(bus.R), 32'h0);
        check("io_rd_ce", 32'(ce_lo), 32'd0);

        // I/O write to hex register
        clear_counts();
        bus.MDR = 16'h0007; bus.WE = 1'b1; bus.Req = 1'b1;
        tick();
        check("io_wr_hex", 32'(bus.HEX_Data), 32'h0007);
        check("io_wr_r", 32'(bus.R), 32'h1);
        bus.Req = 1'b0;
        tick();
        check("io_wr_strobes", 32'(ce_lo + we_lo + oe_lo), 32'd0);
        check("io_wr_r_count", 32'(r_cnt), 32'd1);
        check("io_wr_mdr_in_kept", 32'(bus.MDR_In), 32'h00A5);

        // Reset during ACCESS of a write
        clear_counts();
        bus.MAR = 16'h0100; bus.MDR = 16'h5555; bus.WE = 1'b1; bus.Req = 1'b1;
        tick();
        bus.Req = 1'b0;
        tick();
        check("rst_mid_we_low", 32'(bus.WE_N), 32'h0);
        Reset = 1'b1;
        tick();
        check("rst_mid_we_n", 32'(bus.WE_N), 32'h1);
        check("rst_mid_ce_n", 32'(bus.CE_N), 32'h1);
        check("rst_mid_state", 32'(state_dbg), 32'(ST_IDLE));
        check("rst_mid_hex", 32'(bus.HEX_Data), 32'h0);
        Reset = 1'b0;
        repeat (2) tick();
        check("rst_mid_no_r", 32'(r_cnt), 32'd0);

        // Following read completes normally
        clear_counts();
        bus.MAR = 16'h0200; bus.WE = 1'b0; bus.Data_from_SRAM = 16'hCAFE; bus.Req = 1'b1;
        tick();
        bus.Req = 1'b0;
        repeat (3) tick();
        check("post_rst_r", 32'(bus.R), 32'h1);
        check("post_rst_mdr_in", 32'(bus.MDR_In), 32'hCAFE);
        tick();

        // Req dropped in SETUP, second pulse during ACCESS ignored, third from IDLE runs
        clear_counts();
        bus.MAR = 16'h0300; bus.WE = 1'b0; bus.Data_from_SRAM = 16'h1111; bus.Req = 1'b1;
        tick();
        bus.Req = 1'b0;
        tick();
        bus.Req = 1'b1;
        tick();
        bus.Req = 1'b0;
        tick();
        check("b2b_first_r", 32'(bus.R), 32'h1);
        check("b2b_first_data", 32'(bus.MDR_In), 32'h1111);
        tick();
        check("b2b_back_idle", 32'(state_dbg), 32'(ST_IDLE));
        bus.MAR = 16'h0301; bus.Data_from_SRAM = 16'h2222; bus.Req = 1'b1;
        tick();
        check("b2b_second_setup", 32'(state_dbg), 32'(ST_SETUP));
        bus.Req = 1'b0;
        repeat (3) tick();
        check("b2b_second_data", 32'(bus.MDR_In), 32'h2222);
        repeat (3) tick();
        check("b2b_r_count", 32'(r_cnt), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
